franken_mem_arbiter: RTL and testbench
======================================

Name: franken_mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between three requesters:
  - M0: core data port (load/store stage).
  - M1: core instruction fetch.
  - M2: UART boot loader.
- Sequences boot: after reset only M2 may access the RAM and the core is held; normal round-robin service starts once the loader signals completion.
- Sits between the franken_riscv core, the loader and the RAM macro.

Parameters:
- RAM_AW, 12, word-address width of the RAM; byte address bits [RAM_AW+1:2] are used.
- BOOT_SKIP, 0, if 1 the arbiter resets directly into RUN.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- m_req  in  3  per-requester request, held until granted.
- m_we  in  3  per-requester write flag.
- m_addr  in  3x32  per-requester byte address.
- m_wdata  in  3x32  per-requester write data.
- m_be  in  3x4  per-requester byte enables.
- m_gnt  out  3  one-hot grant, same cycle as the accepted request.
- m_rvalid  out  3  one-hot response, one cycle after the grant.
- m_rdata  out  32  shared read data; valid only with m_rvalid.
- boot_done  in  1  loader pulse that ends BOOT.
- core_hold  out  1  stalls the core pipeline (fetch and data).
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  RAM byte-write strobes.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, one-cycle latency.

Behaviour:
- Reset values:
  - State = BOOT (RUN if BOOT_SKIP).
  - rr_ptr = M0.
  - m_gnt = 0, m_rvalid = 0, m_rdata = 0.
  - core_hold = 1 (0 if BOOT_SKIP).
  - ram_en = 0, ram_we = 0.
- States:
  - BOOT:
    - Only M2 is eligible; M0/M1 requests are ignored (never granted) and core_hold = 1.
    - boot_done = 1 moves to RUN on the next edge.
    - A grant to M2 in the same cycle as boot_done still completes.
  - RUN:
    - Round-robin over M0, M1, M2, starting from rr_ptr.
    - After a grant to Mk, rr_ptr = (k+1) mod 3.
    - core_hold = 0.
    - boot_done is ignored.
- Grant path (combinational, same cycle):
  - m_gnt[k] = 1 for the chosen requester.
  - ram_en = 1 and ram_addr = m_addr[k][RAM_AW+1:2].
  - ram_we = m_we[k] ? m_be[k] : 4'b0000.
  - ram_wdata = m_wdata[k].
- Throughput and latency:
  - At most one grant per cycle; back-to-back grants are allowed (one access per cycle).
  - Response: m_rvalid[k] = 1 exactly one cycle after m_gnt[k], for reads and writes alike.
  - m_rdata = ram_rdata for reads; 0 for writes.
  - The registered response index is kept in a 2-bit resp_idx plus a resp_v flag.
- No request pending: m_gnt = 0, ram_en = 0, rr_ptr unchanged.
- Simultaneous requests from all three with rr_ptr = M1: grant order is M1, M2, M0.
- A requester that drops m_req before it is granted is not served; there is no queue.
- Reset asserted mid-access:
  - Any pending m_rvalid is dropped; the in-flight read response is lost.
  - State returns to BOOT.
- Address bits above RAM_AW+1 are ignored (the address aliases); m_addr[1:0] is ignored.

Optional Feature:
- Macro FRANKEN_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_gnt (3x16) and perf_wait (3x16), zeroed on reset.
  - perf_gnt[k] increments per grant to Mk.
  - perf_wait[k] increments for each cycle m_req[k] = 1 with m_gnt[k] = 0, including BOOT-blocked cycles.
  - Counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package franken_arb_pkg:
  - Requester index constants M_DATA = 0, M_FETCH = 1, M_LOADER = 2.
  - NUM_REQ = 3.
  - State enum {ARB_BOOT, ARB_RUN}.
- Sub-module franken_rr_pick: combinational rotating-priority picker.
  - Inputs: 3-bit request vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.
- The top level holds the FSM, rr_ptr, response register and the RAM mux.

Test Plan:
- Reset, then M0/M1 request address 0x10 with M2 idle:
  - No grants; core_hold = 1.
  - M2 write 0xDEADBEEF to 0x10 with be = 4'hF: gnt[2], ram_we = 4'hF, ram_addr = 4, rvalid[2] on the next cycle.
- boot_done pulse, then M1 reads 0x10:
  - core_hold = 0 one cycle after boot_done.
  - gnt[1]; next cycle rvalid[1] = 1 and m_rdata = 0xDEADBEEF.
- All three requests held with rr_ptr = M0:
  - Grants over 3 consecutive cycles are M0, M1, M2.
  - Responses follow each grant by one cycle.
  - rr_ptr ends at M0.
- M0 byte store, be = 4'b0100, wdata = 0x00AB0000 to 0x12:
  - ram_we = 4'b0100 and ram_addr = 4.
  - A subsequent M1 read of 0x10 returns 0xDEABBEEF.
- Reset asserted in the cycle after an M1 read grant:
  - No rvalid is delivered.
  - State = BOOT and core_hold = 1 after the reset edge.
- FRANKEN_ARB_PERF_EN build: M0 blocked for 5 cycles during BOOT, then granted once:
  - perf_wait[0] = 5 and perf_gnt[0] = 1.

Source files
------------

// File: rtl/franken_arb_pkg.sv
`default_nettype none
// ============================================================================
// franken_arb_pkg : requester indices, state type and helpers for the arbiter
// Revision 1.0
// ============================================================================
package franken_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] M_DATA   = 2'd0;
  localparam logic [1:0] M_FETCH  = 2'd1;
  localparam logic [1:0] M_LOADER = 2'd2;

  typedef enum logic [0:0] {
    ARB_BOOT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  function automatic logic [1:0] next_idx(input logic [1:0] k);
    return (k == M_LOADER) ? M_DATA : k + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/franken_rr_pick.sv
`default_nettype none
// ============================================================================
// franken_rr_pick : combinational rotating-priority picker starting at rr_ptr
// Revision 1.0
// ============================================================================
module franken_rr_pick
  import franken_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         idx_o,
  output logic               valid_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = rr_ptr_i;
    valid_o = 1'b0;
    cand    = rr_ptr_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

endmodule
`default_nettype wire

// File: rtl/franken_mem_arbiter.sv
`default_nettype none
// ============================================================================
// franken_mem_arbiter : boot-sequenced round-robin arbiter for one shared RAM.
// Optional counters: FRANKEN_ARB_PERF_EN.  Revision 1.0
// ============================================================================
module franken_mem_arbiter
  import franken_arb_pkg::*;
#(
  parameter int RAM_AW    = 12,
  parameter bit BOOT_SKIP = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         m_req,
  input  logic [NUM_REQ-1:0]         m_we,
  input  logic [NUM_REQ-1:0][31:0]   m_addr,
  input  logic [NUM_REQ-1:0][31:0]   m_wdata,
  input  logic [NUM_REQ-1:0][3:0]    m_be,
  output logic [NUM_REQ-1:0]         m_gnt,
  output logic [NUM_REQ-1:0]         m_rvalid,
  output logic [31:0]                m_rdata,
  input  logic                       boot_done,
  output logic                       core_hold,
  output logic                       ram_en,
  output logic [3:0]                 ram_we,
  output logic [RAM_AW-1:0]          ram_addr,
  output logic [31:0]                ram_wdata,
  input  logic [31:0]                ram_rdata
`ifdef FRANKEN_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]   perf_gnt,
  output logic [NUM_REQ-1:0][15:0]   perf_wait
`endif
);

  localparam logic [NUM_REQ-1:0] LOADER_MASK = 3'b100;

  arb_state_e         state_q;
  logic               core_hold_q;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               resp_v_q, resp_we_q;
  logic [1:0]         resp_idx_q;
  logic [NUM_REQ-1:0] eligible, pick_gnt;
  logic [1:0]         pick_idx;
  logic               pick_v;
  logic               unused_addr;

  // Reset suppresses new grants so no RAM write slips through during reset.
  always_comb begin
    if (reset)                    eligible = '0;
    else if (state_q == ARB_BOOT) eligible = m_req & LOADER_MASK;
    else                          eligible = m_req;
  end

  franken_rr_pick u_pick (
    .req_i    (eligible),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .valid_o  (pick_v)
  );

  always_comb begin
    m_gnt     = pick_gnt;
    ram_en    = pick_v;
    ram_addr  = m_addr[pick_idx][RAM_AW+1:2];
    ram_we    = (pick_v && m_we[pick_idx]) ? m_be[pick_idx] : 4'b0000;
    ram_wdata = m_wdata[pick_idx];
    rr_ptr_d  = pick_v ? next_idx(pick_idx) : rr_ptr_q;
  end

  always_comb begin
    unused_addr = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      unused_addr = unused_addr ^ (^m_addr[k][31:RAM_AW+2]) ^ (^m_addr[k][1:0]);
    end
  end

  // A response pending when reset arrives is dropped, not delivered.
  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    if (resp_v_q && !reset) begin
      m_rvalid[resp_idx_q] = 1'b1;
      if (!resp_we_q) m_rdata = ram_rdata;
    end
  end

  assign core_hold = core_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT_SKIP ? ARB_RUN : ARB_BOOT;
      core_hold_q <= ~BOOT_SKIP;
      rr_ptr_q    <= M_DATA;
      resp_v_q    <= 1'b0;
      resp_we_q   <= 1'b0;
      resp_idx_q  <= M_DATA;
    end else begin
      case (state_q)
        ARB_BOOT: begin
          if (boot_done) begin
            state_q     <= ARB_RUN;
            core_hold_q <= 1'b0;
          end
        end
        ARB_RUN: core_hold_q <= 1'b0;
      endcase
      rr_ptr_q <= rr_ptr_d;
      resp_v_q <= pick_v;
      if (pick_v) begin
        resp_idx_q <= pick_idx;
        resp_we_q  <= m_we[pick_idx];
      end
    end
  end

`ifdef FRANKEN_ARB_PERF_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_perf
    logic [15:0] gnt_cnt_q, wait_cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        gnt_cnt_q  <= '0;
        wait_cnt_q <= '0;
      end else begin
        if (m_gnt[k] && gnt_cnt_q != 16'hFFFF) gnt_cnt_q <= gnt_cnt_q + 16'd1;
        if (m_req[k] && !m_gnt[k] && wait_cnt_q != 16'hFFFF) wait_cnt_q <= wait_cnt_q + 16'd1;
      end
    end

    assign perf_gnt[k]  = gnt_cnt_q;
    assign perf_wait[k] = wait_cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_franken_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_franken_mem_arbiter : directed and randomized bench for the RAM arbiter
// Revision 1.0
// ============================================================================
module tb_franken_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [2:0]       m_req, m_we;
  logic [2:0][31:0] m_addr, m_wdata;
  logic [2:0][3:0]  m_be;
  logic [2:0]       m_gnt, m_rvalid;
  logic [31:0]      m_rdata;
  logic             boot_done;
  logic             core_hold;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [11:0]      ram_addr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
`ifdef FRANKEN_ARB_PERF_EN
  logic [2:0][15:0] perf_gnt, perf_wait;
`endif

  franken_mem_arbiter #(.RAM_AW(12), .BOOT_SKIP(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_be      (m_be),
    .m_gnt     (m_gnt),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .boot_done (boot_done),
    .core_hold (core_hold),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef FRANKEN_ARB_PERF_EN
    ,
    .perf_gnt  (perf_gnt),
    .perf_wait (perf_wait)
`endif
  );

  // RAM macro stand-in: one-cycle read latency, byte writes
  logic [31:0] bram [0:4095];
  initial for (int i = 0; i < 4096; i++) bram[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) bram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= bram[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:4095];
  bit          mb_booted;
  int          mb_ptr;
  bit          mb_pv;
  int          mb_pidx;
  logic [31:0] mb_pdata;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int exp_pick();
    if (reset) return -1;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (mb_ptr + i) % 3;
      if (m_req[k] && (mb_booted || k == 2)) return k;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_rvalid();
    return (mb_pv && !reset) ? (3'b001 << mb_pidx) : 3'b000;
  endfunction

  task automatic model_step();
    int k;
    k = exp_pick();
    if (reset) begin
      mb_booted = 1'b0;
      mb_ptr    = 0;
      mb_pv     = 1'b0;
    end else begin
      mb_pv = (k >= 0);
      if (k >= 0) begin
        int a;
        a = int'(m_addr[k][13:2]);
        mb_pidx = k;
        if (m_we[k]) begin
          mb_pdata = 32'h0;
          for (int b = 0; b < 4; b++) if (m_be[k][b]) ref_mem[a][8*b +: 8] = m_wdata[k][8*b +: 8];
        end else begin
          mb_pdata = ref_mem[a];
        end
        mb_ptr = (k + 1) % 3;
      end
      if (boot_done) mb_booted = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_req = 3'b111; m_we = 3'b111; #3;
    n_chk++; if (m_gnt !== 3'b000) $display("FAIL rst_gnt got %b want 000", m_gnt); else n_pass++;
    n_chk++; if (ram_en !== 1'b0 || ram_we !== 4'h0) $display("FAIL rst_ram got en=%b we=%h want 0/0", ram_en, ram_we); else n_pass++;
    n_chk++; if (core_hold !== 1'b1) $display("FAIL rst_hold got %b want 1", core_hold); else n_pass++;
    n_chk++; if (m_rvalid !== 3'b000 || m_rdata !== 32'h0) $display("FAIL rst_resp got %b/%h want 000/0", m_rvalid, m_rdata); else n_pass++;
    tick();
    reset = 1'b0; m_req = 3'b000; m_we = 3'b000; #3;
    n_chk++; if (core_hold !== 1'b1 || m_rvalid !== 3'b000) $display("FAIL post_rst got hold=%b rv=%b want 1/000", core_hold, m_rvalid); else n_pass++;
    tick();
  endtask

  task automatic test_boot_block();
    m_req = 3'b011; m_addr[0] = 32'h10; m_addr[1] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_chk++; if (m_gnt !== 3'b000 || ram_en !== 1'b0) $display("FAIL boot_block got gnt=%b en=%b want 000/0", m_gnt, ram_en); else n_pass++;
      n_chk++; if (core_hold !== 1'b1) $display("FAIL boot_hold got %b want 1", core_hold); else n_pass++;
      tick();
    end
    m_req = 3'b111; m_we = 3'b100; m_addr[2] = 32'h10; m_wdata[2] = 32'hDEADBEEF; m_be[2] = 4'hF; #3;
    n_chk++; if (m_gnt !== 3'b100) $display("FAIL boot_m2_gnt got %b want 100", m_gnt); else n_pass++;
    n_chk++; if (ram_we !== 4'hF || ram_addr !== 12'd4 || ram_wdata !== 32'hDEADBEEF)
      $display("FAIL boot_m2_ram got we=%h a=%0d d=%h want F/4/deadbeef", ram_we, ram_addr, ram_wdata); else n_pass++;
    tick();
    m_req = 3'b000; m_we = 3'b000; #3;
    n_chk++; if (m_rvalid !== 3'b100 || m_rdata !== 32'h0) $display("FAIL boot_m2_rv got %b/%h want 100/0", m_rvalid, m_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_boot_done();
    boot_done = 1'b1; #3;
    n_chk++; if (core_hold !== 1'b1) $display("FAIL bd_hold_same got %b want 1", core_hold); else n_pass++;
    tick();
    boot_done = 1'b0; m_req = 3'b010; m_addr[1] = 32'h10; #3;
    n_chk++; if (core_hold !== 1'b0) $display("FAIL bd_hold_next got %b want 0", core_hold); else n_pass++;
    n_chk++; if (m_gnt !== 3'b010) $display("FAIL bd_m1_gnt got %b want 010", m_gnt); else n_pass++;
    tick();
    m_req = 3'b000; #3;
    n_chk++; if (m_rvalid !== 3'b010 || m_rdata !== 32'hDEADBEEF) $display("FAIL bd_m1_rd got %b/%h want 010/deadbeef", m_rvalid, m_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] order [3];
    logic [2:0] prev;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    m_req = 3'b100; m_addr[2] = 32'h0; #3;
    n_chk++; if (m_gnt !== 3'b100) $display("FAIL rr_pre got %b want 100", m_gnt); else n_pass++;
    tick();
    m_req = 3'b111; m_addr[0] = 32'h0; m_addr[1] = 32'h4; m_addr[2] = 32'h8;
    prev = 3'b100;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_chk++; if (m_gnt !== order[i]) $display("FAIL rr_gnt%0d got %b want %b", i, m_gnt, order[i]); else n_pass++;
      n_chk++; if (m_rvalid !== prev) $display("FAIL rr_rv%0d got %b want %b", i, m_rvalid, prev); else n_pass++;
      tick();
      m_req = m_req & ~order[i];
      prev = order[i];
    end
    m_req = 3'b111; #3;
    n_chk++; if (m_gnt !== 3'b001) $display("FAIL rr_wrap got %b want 001", m_gnt); else n_pass++;
    n_chk++; if (m_rvalid !== 3'b100) $display("FAIL rr_rv3 got %b want 100", m_rvalid); else n_pass++;
    tick();
    m_req = 3'b000; tick();
  endtask

  task automatic test_byte_store();
    m_req = 3'b001; m_we = 3'b001; m_addr[0] = 32'h12; m_wdata[0] = 32'h00AB0000; m_be[0] = 4'b0100; #3;
    n_chk++; if (ram_we !== 4'b0100 || ram_addr !== 12'd4) $display("FAIL bs_ram got we=%b a=%0d want 0100/4", ram_we, ram_addr); else n_pass++;
    tick();
    m_req = 3'b010; m_we = 3'b000; m_addr[1] = 32'h10; #3;
    n_chk++; if (m_gnt !== 3'b010 || m_rvalid !== 3'b001) $display("FAIL bs_rd_gnt got %b/%b want 010/001", m_gnt, m_rvalid); else n_pass++;
    tick();
    m_req = 3'b000; #3;
    n_chk++; if (m_rvalid !== 3'b010 || m_rdata !== 32'hDEABBEEF) $display("FAIL bs_rd got %b/%h want 010/deabbeef", m_rvalid, m_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int k;
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      m_req     = 3'($urandom);
      m_we      = 3'($urandom);
      boot_done = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 3; j++) begin
        m_addr[j]  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
        m_wdata[j] = $urandom;
        m_be[j]    = 4'($urandom);
      end
      #3;
      k = exp_pick();
      n_chk++;
      if (m_gnt !== ((k < 0) ? 3'b000 : (3'b001 << k)) || ram_en !== (k >= 0) || core_hold !== !mb_booted) begin
        $display("FAIL rnd_gnt c=%0d got gnt=%b en=%b hold=%b want pick=%0d", c, m_gnt, ram_en, core_hold, k);
        errs++;
      end else n_pass++;
      if (k >= 0) begin
        n_chk++;
        if (ram_addr !== m_addr[k][13:2] || ram_wdata !== m_wdata[k] || ram_we !== (m_we[k] ? m_be[k] : 4'h0))
          $display("FAIL rnd_ram c=%0d got a=%h we=%h d=%h want a=%h", c, ram_addr, ram_we, ram_wdata, m_addr[k][13:2]);
        else n_pass++;
      end
      n_chk++;
      if (m_rvalid !== exp_rvalid() || m_rdata !== (mb_pv ? mb_pdata : 32'h0))
        $display("FAIL rnd_resp c=%0d got %b/%h want %b/%h", c, m_rvalid, m_rdata, exp_rvalid(), mb_pv ? mb_pdata : 32'h0);
      else n_pass++;
      tick();
      if (errs > 20) break;
    end
    m_req = 3'b000; m_we = 3'b000; boot_done = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    m_req = 3'b010; m_we = 3'b000; m_addr[1] = 32'h10; #3;
    n_chk++; if (m_gnt !== 3'b010) $display("FAIL rm_gnt got %b want 010", m_gnt); else n_pass++;
    tick();
    m_req = 3'b001; reset = 1'b1; #3;
    n_chk++; if (m_rvalid !== 3'b000 || m_gnt !== 3'b000) $display("FAIL rm_drop got rv=%b gnt=%b want 000/000", m_rvalid, m_gnt); else n_pass++;
    tick();
    reset = 1'b0; #3;
    n_chk++; if (core_hold !== 1'b1 || m_gnt !== 3'b000 || m_rvalid !== 3'b000)
      $display("FAIL rm_boot got hold=%b gnt=%b rv=%b want 1/000/000", core_hold, m_gnt, m_rvalid); else n_pass++;
    tick();
    m_req = 3'b000; tick();
  endtask

`ifdef FRANKEN_ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b1; m_req = 3'b000; tick();
    reset = 1'b0; m_req = 3'b001; m_we = 3'b000; m_addr[0] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      boot_done = (i == 4);
      tick();
    end
    boot_done = 1'b0; #3;
    n_chk++; if (m_gnt !== 3'b001) $display("FAIL perf_gnt_now got %b want 001", m_gnt); else n_pass++;
    tick();
    m_req = 3'b000; #3;
    n_chk++; if (perf_wait[0] !== 16'd5 || perf_gnt[0] !== 16'd1)
      $display("FAIL perf_cnt got wait=%0d gnt=%0d want 5/1", perf_wait[0], perf_gnt[0]); else n_pass++;
    n_chk++; if (perf_wait[1] !== 16'd0 || perf_gnt[2] !== 16'd0)
      $display("FAIL perf_idle got wait1=%0d gnt2=%0d want 0/0", perf_wait[1], perf_gnt[2]); else n_pass++;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    mb_booted = 1'b0; mb_ptr = 0; mb_pv = 1'b0; mb_pidx = 0; mb_pdata = 32'h0;
    reset = 1'b1; boot_done = 1'b0;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_boot_block();
    test_boot_done();
    test_round_robin();
    test_byte_store();
    test_random();
    test_reset_mid();
`ifdef FRANKEN_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
